// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, widths and the fetch-unit state type.
package cpu_pkg;

   localparam int unsigned INSTR_W    = 32;
   localparam int unsigned WORD_BYTES = 4;

   localparam logic [5:0] OPC_J    = 6'b000010;
   localparam logic [5:0] OPC_BEQ  = 6'b000100;
   localparam logic [5:0] OPC_ADDI = 6'b001000;

   typedef enum logic {
      RUN,
      HALT
   } fetch_state_e;

endpackage

// File: rtl/jump_predecode.sv
// Combinational pre-decode of the fetched word: spots `j`, computes its
// target and flags the self-loop idiom used to end a program.
module jump_predecode
   import cpu_pkg::*;
(
   input  logic [INSTR_W-1:0] instr_i,
   input  logic [31:0]        pc_i,
   output logic               is_jump_o,
   output logic [31:0]        jump_target_o,
   output logic               is_self_loop_o,
   output logic [31:0]        pc_plus4_o
);

   always_comb begin
      pc_plus4_o     = pc_i + 32'(WORD_BYTES);
      is_jump_o      = (instr_i[31:26] == OPC_J);
      // Region bits come from the address of the delay slot, not the jump itself.
      jump_target_o  = {pc_plus4_o[31:28], instr_i[25:0], 2'b00};
      is_self_loop_o = is_jump_o && (jump_target_o == pc_i);
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, reads the combinational instruction memory and
// hands instructions to decode over valid/ready; halts on a self-loop jump.
module instruction_fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'd0,
   parameter int unsigned COUNT_W  = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic [31:0]        imem_addr,
   input  logic [31:0]        imem_instr,
   input  logic               redirect_valid,
   input  logic [31:0]        redirect_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        out_instr,
   output logic [31:0]        out_pc,
   output logic               halted,
   output logic [COUNT_W-1:0] fetch_count
);

   fetch_state_e       state_q, state_d;
   logic [31:0]        pc_q, pc_d;
   logic               out_valid_q, out_valid_d;
   logic [31:0]        out_instr_q, out_instr_d;
   logic [31:0]        out_pc_q, out_pc_d;
   logic [COUNT_W-1:0] count_q, count_d;

   logic               fire;
   logic               is_jump;
   logic               is_self_loop;
   logic [31:0]        jump_target;
   logic [31:0]        pc_plus4;
   logic [31:0]        next_pc;

   jump_predecode u_predecode (
      .instr_i        (imem_instr),
      .pc_i           (pc_q),
      .is_jump_o      (is_jump),
      .jump_target_o  (jump_target),
      .is_self_loop_o (is_self_loop),
      .pc_plus4_o     (pc_plus4)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= RUN;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (redirect_valid) begin
         state_d = RUN;
      end else begin
         case (state_q)
            RUN:     if (fire && is_self_loop) state_d = HALT;
            HALT:    state_d = HALT;
            default: state_d = RUN;
         endcase
      end
   end

   always_comb begin
      fire   = (state_q == RUN) && !redirect_valid && (!out_valid_q || out_ready);
      halted = (state_q == HALT);
   end

   always_comb begin
      next_pc     = is_jump ? jump_target : pc_plus4;
      pc_d        = pc_q;
      out_valid_d = out_valid_q;
      out_instr_d = out_instr_q;
      out_pc_d    = out_pc_q;
      // Redirect flushes whatever is held, even mid-stall.
      if (redirect_valid) begin
         pc_d        = redirect_pc & ~32'd3;
         out_valid_d = 1'b0;
      end else if (fire) begin
         pc_d        = next_pc;
         out_valid_d = 1'b1;
         out_instr_d = imem_instr;
         out_pc_d    = pc_q;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end

      count_d = count_q;
      if (out_valid_q && out_ready) count_d = count_q + COUNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q        <= RESET_PC;
         out_valid_q <= 1'b0;
         out_instr_q <= '0;
         out_pc_q    <= '0;
         count_q     <= '0;
      end else begin
         pc_q        <= pc_d;
         out_valid_q <= out_valid_d;
         out_instr_q <= out_instr_d;
         out_pc_q    <= out_pc_d;
         count_q     <= count_d;
      end
   end

   assign imem_addr   = pc_q;
   assign out_valid   = out_valid_q;
   assign out_instr   = out_instr_q;
   assign out_pc      = out_pc_q;
   assign fetch_count = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed program walk, then random
// memory/ready/redirect traffic checked against a program-order stream model.
module tb_instruction_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] imem_addr, imem_instr;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid, out_ready;
   logic [31:0] out_instr, out_pc;
   logic        halted;
   logic [15:0] fetch_count;

   always #5 clk = ~clk;

   instruction_fetch_unit #(.RESET_PC(32'd0), .COUNT_W(16)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_addr      (imem_addr),
      .imem_instr     (imem_instr),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .halted         (halted),
      .fetch_count    (fetch_count)
   );

   logic [31:0] mem [0:63];
   assign imem_instr = (imem_addr[31:8] == 24'd0) ? mem[imem_addr[7:2]] : 32'd0;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (a[31:8] != 24'd0) return 32'd0;
      return mem[a[7:2]];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic walk_to(input logic [31:0] t, input string name);
      bit found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         step();
         if (out_valid === 1'b1 && out_pc === t) found = 1'b1;
      end
      chk({name, "_reach"}, {31'd0, found}, 32'd1);
   endtask

   // Expected delivery stream in program order
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   exp_t        q[$];
   logic [31:0] gen_pc;
   bit          gen_done;
   logic [15:0] m_count;
   bit          mon_en = 1'b0;

   task automatic gen_topup();
      logic [31:0] ins, tgt, p4;
      while (!gen_done && q.size() < 4) begin
         ins = mem_rd(gen_pc);
         q.push_back('{pc: gen_pc, instr: ins});
         p4 = gen_pc + 32'd4;
         if (ins[31:26] == 6'b000010) begin
            tgt = {p4[31:28], ins[25:0], 2'b00};
            if (tgt == gen_pc) gen_done = 1'b1;
            else               gen_pc   = tgt;
         end else begin
            gen_pc = p4;
         end
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         chk("fetch_count", {16'd0, fetch_count}, {16'd0, m_count});
         if (gen_done && q.size() == 0) begin
            chk("halt_flag", {31'd0, halted}, 32'd1);
            chk("halt_idle", {31'd0, out_valid}, 32'd0);
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_out actual_pc=%h expected=none", out_pc);
            end else begin
               e = q.pop_front();
               chk("sb_pc", out_pc, e.pc);
               chk("sb_instr", out_instr, e.instr);
            end
            m_count = m_count + 16'd1;
         end
      end
   end

   bit track52 = 1'b0;
   bit saw52   = 1'b0;
   always @(negedge clk) if (track52 && imem_addr == 32'd52) saw52 = 1'b1;

   initial begin
      logic [15:0] cnt0;
      logic [31:0] rpc;
      bit          redir_prev;

      for (int i = 0; i < 64; i++) mem[i] = 32'h2000_0000 + 32'(i) * 32'h0001_0001;
      mem[0]  = 32'h210800D5;
      mem[1]  = 32'h2129003C;
      mem[2]  = 32'h214A0009;
      mem[12] = 32'h08000011;
      mem[13] = 32'h22520001;
      mem[18] = 32'h08000013;
      mem[19] = 32'h08000013;

      rst_n = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0;
      #2;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_instr", out_instr, 32'd0);
      chk("rst_out_pc", out_pc, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd0);
      chk("rst_count", {16'd0, fetch_count}, 32'd0);
      step();
      rst_n = 1'b1;
      chk("pre_edge_addr", imem_addr, 32'd0);
      chk("pre_edge_valid", {31'd0, out_valid}, 32'd0);

      step();
      chk("e1_instr", out_instr, 32'h210800D5);
      chk("e1_pc", out_pc, 32'd0);
      step();
      chk("e2_pc", out_pc, 32'd4);
      chk("e2_instr", out_instr, 32'h2129003C);
      step();
      chk("e3_pc", out_pc, 32'd8);

      out_ready = 1'b0;
      cnt0 = fetch_count;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_pc", out_pc, 32'd8);
         chk("stall_instr", out_instr, 32'h214A0009);
         chk("stall_addr", imem_addr, 32'd12);
         chk("stall_count", {16'd0, fetch_count}, {16'd0, cnt0});
      end
      out_ready = 1'b1;
      step();
      chk("unstall_pc", out_pc, 32'd12);
      chk("unstall_valid", {31'd0, out_valid}, 32'd1);

      track52 = 1'b1;
      walk_to(32'd48, "to48");
      chk("j_addr", imem_addr, 32'd68);
      step();
      chk("j_next_pc", out_pc, 32'd68);
      chk("j_next_valid", {31'd0, out_valid}, 32'd1);
      walk_to(32'd72, "to72");
      step();
      chk("loop_pc", out_pc, 32'd76);
      chk("loop_halted", {31'd0, halted}, 32'd1);
      chk("loop_addr", imem_addr, 32'd76);
      track52 = 1'b0;
      chk("no_addr52", {31'd0, saw52}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("halt_bubble", {31'd0, out_valid}, 32'd0);
      end
      chk("halt_addr", imem_addr, 32'd76);
      chk("halt_stays", {31'd0, halted}, 32'd1);

      redirect_valid = 1'b1; redirect_pc = 32'd0;
      step();
      redirect_valid = 1'b0;
      chk("resume_halted", {31'd0, halted}, 32'd0);
      chk("resume_addr", imem_addr, 32'd0);
      walk_to(32'd28, "to28");
      chk("inflight_addr", imem_addr, 32'd32);
      cnt0 = fetch_count;
      redirect_valid = 1'b1; redirect_pc = 32'd53;
      step();
      redirect_valid = 1'b0;
      chk("redir_flush", {31'd0, out_valid}, 32'd0);
      chk("redir_addr", imem_addr, 32'd52);
      chk("redir_count", {16'd0, fetch_count}, {16'd0, cnt0 + 16'd1});
      step();
      chk("redir_pc", out_pc, 32'd52);
      chk("redir_instr", out_instr, 32'h22520001);

      walk_to(32'd76, "to76");
      redirect_valid = 1'b1; redirect_pc = 32'd0;
      step();
      redirect_valid = 1'b0;
      walk_to(32'd20, "to20");
      out_ready = 1'b0;
      step();
      chk("pre_rst_pc", out_pc, 32'd20);
      #3 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_pc", out_pc, 32'd0);
      chk("mid_rst_instr", out_instr, 32'd0);
      chk("mid_rst_addr", imem_addr, 32'd0);
      chk("mid_rst_count", {16'd0, fetch_count}, 32'd0);
      chk("mid_rst_halted", {31'd0, halted}, 32'd0);

      // Random program: mostly non-jumps, some jumps, occasional self-loops
      for (int i = 0; i < 64; i++) begin
         int unsigned r;
         logic [31:0] w;
         r = $urandom_range(9);
         if (r == 0)      w = {6'b000010, 20'd0, 6'($urandom_range(63))};
         else if (r == 1) w = {6'b000010, 20'd0, 6'(i)};
         else if (r == 2) w = 32'd0;
         else begin
            w = $urandom;
            if (w[31:26] == 6'b000010) w[31] = 1'b1;
         end
         mem[i] = w;
      end
      q.delete();
      gen_pc = 32'd0; gen_done = 1'b0; m_count = 16'd0;
      gen_topup();
      out_ready = 1'b1; redirect_valid = 1'b0;
      step();
      rst_n = 1'b1;
      mon_en = 1'b1;
      redir_prev = 1'b0;
      rpc = 32'd0;
      for (int c = 0; c < 2000; c++) begin
         step();
         if (redir_prev) begin
            q.delete();
            gen_pc   = rpc & ~32'd3;
            gen_done = 1'b0;
         end
         gen_topup();
         out_ready      = ($urandom_range(3) != 0);
         redir_prev     = ($urandom_range(24) == 0);
         redirect_valid = redir_prev;
         redirect_pc    = $urandom_range(255);
         rpc            = redirect_pc;
      end
      redirect_valid = 1'b0;
      step();
      mon_en = 1'b0;
      chk("accepts_seen", {31'd0, (m_count > 16'd100)}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Consumer side of the instruction-memory interface. Owns the PC, drives the word address into the combinational instruction_memory and captures the returned instruction word.
- Delivers each instruction with its PC to decode over a valid/ready handshake.
- Pre-decodes `j` to redirect itself without a bubble, and accepts redirects from execute (taken `beq`).
- Detects the self-loop `j end_program` idiom and halts fetch.

Parameters:
- RESET_PC, 32'd0, PC loaded on reset; must be a multiple of 4.
- COUNT_W, 16, width of the delivered-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_addr  output  32  byte address to instruction_memory; equals the PC register.
- imem_instr  input  32  instruction word returned combinationally for imem_addr.
- redirect_valid  input  1  execute-stage redirect request (taken branch).
- redirect_pc  input  32  redirect target; bits [1:0] are ignored and forced to 0.
- out_valid  output  1  out_instr/out_pc hold a valid instruction.
- out_ready  input  1  decode accepts when out_valid && out_ready.
- out_instr  output  32  fetched instruction.
- out_pc  output  32  address of out_instr.
- halted  output  1  fetch stopped on a self-loop jump.
- fetch_count  output  COUNT_W  count of instructions accepted by decode; wraps modulo 2^COUNT_W.

Behaviour:
- Reset (async, rst_n=0) sets:
  - pc=RESET_PC, so imem_addr=RESET_PC.
  - out_valid=0, out_instr=0, out_pc=0.
  - halted=0, fetch_count=0, state=RUN.
- FSM has two states: RUN and HALT.
- fire = (state==RUN) && !redirect_valid && (!out_valid || out_ready).
- On fire at a rising edge:
  - out_instr<=imem_instr, out_pc<=pc, out_valid<=1.
  - pc<=next_pc.
- next_pc:
  - If imem_instr[31:26]==6'b000010 (j): {pc_plus4[31:28], imem_instr[25:0], 2'b00}, where pc_plus4=pc+4 (32-bit, wraps).
  - Otherwise: pc+4.
- Self-loop: if a fired instruction is `j` and its target equals pc, then pc holds, state<=HALT and halted<=1 at the same edge. The jump itself is still delivered once.
- In HALT, no fetch; imem_addr stays at the loop address.
- Latency: an address presented in cycle N has its instruction on out_* after edge N+1. Sequential fetch gives one instruction per cycle. `j` costs zero bubbles.
- Stall: out_valid && !out_ready holds out_*, pc and imem_addr stable. Nothing is dropped or duplicated.
- No fire and out_ready=1: out_valid<=0 (bubble, e.g. in HALT after the last instruction is consumed).
- Redirect has top priority over fire, stall and HALT. redirect_valid=1 at an edge causes:
  - pc<=redirect_pc & ~32'd3.
  - out_valid<=0: the held or in-flight instruction is flushed, even if out_ready was low.
  - state<=RUN, halted<=0.
  - The first instruction from the target appears after the following edge (one bubble).
- Simultaneous redirect and out_ready: the handshake still completes and fetch_count increments.
- fetch_count increments on every out_valid && out_ready.
- imem_instr==0 (unmapped default) is an ordinary NOP (sll); it is fetched and passed through.
- Reset mid-operation: all state returns to reset values immediately, independent of clk.

Decomposition:
- Shared package (cpu_pkg):
  - OPC_J=6'b000010, OPC_BEQ=6'b000100, OPC_ADDI=6'b001000.
  - INSTR_W=32, WORD_BYTES=4.
  - Fetch-state enum {RUN, HALT}.
- One natural sub-module, jump_predecode: combinational; from instr and pc, outputs is_jump, jump_target, is_self_loop.
- PC register, output register, FSM and counter stay in the top.

Test Plan:
- Reset, then release with out_ready=1 and the standard program loaded:
  - Before the first edge: imem_addr=0, out_valid=0.
  - After edge 1: out_instr=32'h210800D5, out_pc=0.
  - After edge 2: out_pc=4, out_instr=32'h2129003C.
- out_ready=0 for 3 cycles while out_pc=8:
  - out_instr=32'h214A0009 is held.
  - imem_addr stays 12; fetch_count is unchanged.
  - When ready rises, out_pc=12 follows with no gap.
- Jump at 48 (`j 0x11`): out_pc goes 48 then 68 on consecutive cycles. Address 52 is never presented on imem_addr.
- redirect_valid=1, redirect_pc=32'd53 in the cycle out_pc=28 (with the 32 fetch in flight):
  - Next edge: out_valid=0.
  - Edge after that: out_pc=52, out_instr=32'h22520001.
- Halt path: delivery reaches 72 (`j 0x13`), then 76 (`j 0x13`, self-loop).
  - halted=1 after 76 fires and imem_addr stays 76.
  - After 76 is consumed, out_valid=0 permanently.
  - A later redirect to 0 resumes fetch with halted=0.
- rst_n pulsed low mid-stall at out_pc=20: outputs clear immediately, imem_addr=0, fetch_count=0.
